// File: rtl/axi4_lite_arb_pkg.sv
// Shared types and constants for the AXI4-Lite local-bus arbiter.
//   state_t : arbiter FSM state encoding (2 bits)
//   STRB_W  : byte-strobe width of one requester / the master
//   MAX_REQ : largest supported requester count
//   IDX_W   : width of a requester index
package axi4_lite_arb_pkg;

    localparam int unsigned STRB_W  = 4;
    localparam int unsigned MAX_REQ = 4;
    localparam int unsigned IDX_W   = $clog2(MAX_REQ);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/axi4_lite_bus_arbiter_if.sv
// Local-bus requester side plus AXI4-Lite master command side of the arbiter.
//   REQ_*  : per-requester request level, strobes, address, write data, done, read data
//   GRANT  : one-hot current owner
//   BUS_*  : command to / status from the AXI4-Lite master
// modport master : the arbiter (drives GRANT, REQ_DONE/RDATA and the BUS_* command)
// modport slave  : the environment (requesters and the AXI4-Lite master)
interface axi4_lite_bus_arbiter_if
    import axi4_lite_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32
);

    logic [NUM_REQ-1:0]        REQ_ENA;
    logic [NUM_REQ*STRB_W-1:0] REQ_WSTB;
    logic [NUM_REQ*ADDR_W-1:0] REQ_ADDR;
    logic [NUM_REQ*DATA_W-1:0] REQ_WDATA;
    logic [NUM_REQ-1:0]        REQ_DONE;
    logic [DATA_W-1:0]         REQ_RDATA;
    logic [NUM_REQ-1:0]        GRANT;
    logic                      BUS_ENA;
    logic [STRB_W-1:0]         BUS_WSTB;
    logic [ADDR_W-1:0]         BUS_ADDR;
    logic [DATA_W-1:0]         BUS_WDATA;
    logic                      BUS_WAIT;
    logic [DATA_W-1:0]         BUS_RDATA;

    modport master (
        input  REQ_ENA, REQ_WSTB, REQ_ADDR, REQ_WDATA, BUS_WAIT, BUS_RDATA,
        output REQ_DONE, REQ_RDATA, GRANT, BUS_ENA, BUS_WSTB, BUS_ADDR, BUS_WDATA
    );

    modport slave (
        output REQ_ENA, REQ_WSTB, REQ_ADDR, REQ_WDATA, BUS_WAIT, BUS_RDATA,
        input  REQ_DONE, REQ_RDATA, GRANT, BUS_ENA, BUS_WSTB, BUS_ADDR, BUS_WDATA
    );

endinterface

// File: rtl/axi4_lite_rr_pick.sv
// Combinational round-robin picker.
//   req        : request vector
//   last_grant : index of the previous owner; search starts one above it
//   gnt        : one-hot winner, zero when req is zero
module axi4_lite_rr_pick
    import axi4_lite_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] gnt
);

    int   cand;
    logic found;

    // Walk indices last_grant+1 .. last_grant+NUM_REQ (mod NUM_REQ); first hit wins.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        cand  = 0;
        for (int i = 1; i <= int'(NUM_REQ); i++) begin
            cand = (int'(last_grant) + i) % int'(NUM_REQ);
            for (int j = 0; j < int'(NUM_REQ); j++) begin
                if (!found && (j == cand) && req[j]) begin
                    gnt[j] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/axi4_lite_bus_arbiter.sv
// Round-robin arbiter multiplexing NUM_REQ local-bus requesters onto one
// AXI4-Lite master command port. One transaction at a time:
// IDLE -> ISSUE (BUS_ENA pulse) -> WAIT (until BUS_WAIT low) -> DONE (REQ_DONE pulse).
//   CLK, ARESETn : clock, asynchronous active-low reset
//   bus          : requester and master signals (see axi4_lite_bus_arbiter_if)
module axi4_lite_bus_arbiter
    import axi4_lite_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32
) (
    input  logic                     CLK,
    input  logic                     ARESETn,
    axi4_lite_bus_arbiter_if.master  bus
);

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]     grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0]     last_grant_q, last_grant_d;
    logic                 bus_ena_q, bus_ena_d;
    logic [STRB_W-1:0]    wstb_q, wstb_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;

    logic [NUM_REQ-1:0]   pick_gnt;
    logic [IDX_W-1:0]     pick_idx;
    logic [STRB_W-1:0]    wstb_sel;
    logic [ADDR_W-1:0]    addr_sel;
    logic [DATA_W-1:0]    wdata_sel;

    axi4_lite_rr_pick #(
        .NUM_REQ    (NUM_REQ)
    ) u_pick (
        .req        (bus.REQ_ENA),
        .last_grant (last_grant_q),
        .gnt        (pick_gnt)
    );

    // One-hot mux of the winning requester's command fields and its index.
    always_comb begin
        pick_idx  = '0;
        wstb_sel  = '0;
        addr_sel  = '0;
        wdata_sel = '0;
        for (int j = 0; j < int'(NUM_REQ); j++) begin
            if (pick_gnt[j]) begin
                pick_idx  = IDX_W'(j);
                wstb_sel  = bus.REQ_WSTB[j*STRB_W +: STRB_W];
                addr_sel  = bus.REQ_ADDR[j*ADDR_W +: ADDR_W];
                wdata_sel = bus.REQ_WDATA[j*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state and next-output logic; command fields hold from ISSUE through DONE.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        grant_idx_d  = grant_idx_q;
        last_grant_d = last_grant_q;
        bus_ena_d    = 1'b0;
        wstb_d       = wstb_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        done_d       = '0;
        rdata_d      = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (|bus.REQ_ENA) begin
                    grant_d     = pick_gnt;
                    grant_idx_d = pick_idx;
                    wstb_d      = wstb_sel;
                    addr_d      = addr_sel;
                    wdata_d     = wdata_sel;
                    bus_ena_d   = 1'b1;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (!bus.BUS_WAIT) begin
                    rdata_d = bus.BUS_RDATA;
                    done_d  = grant_q;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                grant_d      = '0;
                last_grant_d = grant_idx_q;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge CLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Registered outputs and arbitration history.
    always_ff @(posedge CLK or negedge ARESETn) begin
        if (!ARESETn) begin
            grant_q      <= '0;
            grant_idx_q  <= '0;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            bus_ena_q    <= 1'b0;
            wstb_q       <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            done_q       <= '0;
            rdata_q      <= '0;
        end else begin
            grant_q      <= grant_d;
            grant_idx_q  <= grant_idx_d;
            last_grant_q <= last_grant_d;
            bus_ena_q    <= bus_ena_d;
            wstb_q       <= wstb_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            done_q       <= done_d;
            rdata_q      <= rdata_d;
        end
    end

    assign bus.GRANT     = grant_q;
    assign bus.BUS_ENA   = bus_ena_q;
    assign bus.BUS_WSTB  = wstb_q;
    assign bus.BUS_ADDR  = addr_q;
    assign bus.BUS_WDATA = wdata_q;
    assign bus.REQ_DONE  = done_q;
    assign bus.REQ_RDATA = rdata_q;

endmodule

// File: tb/tb_axi4_lite_bus_arbiter.sv
// Directed bench for axi4_lite_bus_arbiter with two requesters. Expected bus
// commands are queued when a request is driven and popped when BUS_ENA appears.
module tb_axi4_lite_bus_arbiter;

    localparam int unsigned NREQ = 2;

    typedef struct packed {
        logic [1:0]  gnt;
        logic [3:0]  wstb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;

    logic CLK;
    logic ARESETn;
    int   n_chk;
    int   n_pass;
    int   n_fail;
    exp_t exp_q[$];
    logic [31:0] model_rdata;
    int   waited;

    axi4_lite_bus_arbiter_if #(.NUM_REQ(NREQ), .ADDR_W(32), .DATA_W(32)) bus ();

    axi4_lite_bus_arbiter #(
        .NUM_REQ (NREQ),
        .ADDR_W  (32),
        .DATA_W  (32)
    ) dut (
        .CLK     (CLK),
        .ARESETn (ARESETn),
        .bus     (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_req(input int r, input logic [3:0] wstb, input logic [31:0] addr,
                           input logic [31:0] wdata);
        bus.REQ_WSTB[r*4 +: 4]   = wstb;
        bus.REQ_ADDR[r*32 +: 32] = addr;
        bus.REQ_WDATA[r*32 +: 32] = wdata;
    endtask

    task automatic push_exp(input logic [1:0] g, input logic [3:0] wstb,
                            input logic [31:0] addr, input logic [31:0] wdata);
        exp_t e;
        e.gnt = g; e.wstb = wstb; e.addr = addr; e.wdata = wdata;
        exp_q.push_back(e);
    endtask

    // Plays the AXI4-Lite master for one transaction: BUS_WAIT drops 'delay'
    // cycles after BUS_ENA. Returns cycles spent waiting for BUS_ENA.
    task automatic service(input int delay, input logic [31:0] rd, input logic drop0,
                           input logic chg_wdata, output int wt);
        exp_t e;
        wt = 0;
        while (!bus.BUS_ENA && wt < 20) begin
            step();
            wt++;
        end
        if (!bus.BUS_ENA) begin
            chk("bus_ena_timeout", 64'(bus.BUS_ENA), 64'd1);
            return;
        end
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 64'(exp_q.size()), 64'd1);
            return;
        end
        e = exp_q.pop_front();
        chk("grant", 64'(bus.GRANT), 64'(e.gnt));
        chk("bus_wstb", 64'(bus.BUS_WSTB), 64'(e.wstb));
        chk("bus_addr", 64'(bus.BUS_ADDR), 64'(e.addr));
        chk("bus_wdata", 64'(bus.BUS_WDATA), 64'(e.wdata));
        for (int k = 1; k <= delay; k++) begin
            step();
            chk("bus_ena_one_cycle", 64'(bus.BUS_ENA), 64'd0);
            chk("no_early_done", 64'(bus.REQ_DONE), 64'd0);
            chk("wdata_hold", 64'(bus.BUS_WDATA), 64'(e.wdata));
            chk("grant_onehot0", 64'($onehot0(bus.GRANT)), 64'd1);
            if (k == 1) begin
                if (drop0) bus.REQ_ENA[0] = 1'b0;
                if (chg_wdata) bus.REQ_WDATA = ~bus.REQ_WDATA;
            end
            if (k == delay) begin
                bus.BUS_WAIT = 1'b0;
                if (e.wstb == 4'h0) bus.BUS_RDATA = rd;
                model_rdata = bus.BUS_RDATA;
            end
        end
        step();
        bus.BUS_WAIT = 1'b1;
        chk("req_done", 64'(bus.REQ_DONE), 64'(e.gnt));
        chk("req_rdata", 64'(bus.REQ_RDATA), 64'(model_rdata));
        chk("wdata_hold_done", 64'(bus.BUS_WDATA), 64'(e.wdata));
        chk("grant_in_done", 64'(bus.GRANT), 64'(e.gnt));
        step();
        chk("done_single_pulse", 64'(bus.REQ_DONE), 64'd0);
        chk("grant_cleared", 64'(bus.GRANT), 64'd0);
    endtask

    initial begin
        n_chk = 0; n_pass = 0; n_fail = 0;
        model_rdata   = 32'h0;
        ARESETn       = 1'b0;
        bus.REQ_ENA   = '0;
        bus.REQ_WSTB  = '0;
        bus.REQ_ADDR  = '0;
        bus.REQ_WDATA = '0;
        bus.BUS_WAIT  = 1'b1;
        bus.BUS_RDATA = '0;
        step();
        step();
        chk("rst_grant", 64'(bus.GRANT), 64'd0);
        chk("rst_bus_ena", 64'(bus.BUS_ENA), 64'd0);
        chk("rst_bus_addr", 64'(bus.BUS_ADDR), 64'd0);
        chk("rst_req_done", 64'(bus.REQ_DONE), 64'd0);
        chk("rst_req_rdata", 64'(bus.REQ_RDATA), 64'd0);
        ARESETn = 1'b1;
        step();

        // Spurious BUS_WAIT low while idle.
        bus.BUS_WAIT = 1'b0;
        bus.BUS_RDATA = 32'hBAD0BAD0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("spurious_done", 64'(bus.REQ_DONE), 64'd0);
            chk("spurious_grant", 64'(bus.GRANT), 64'd0);
            chk("spurious_ena", 64'(bus.BUS_ENA), 64'd0);
        end
        bus.BUS_WAIT = 1'b1;
        step();
        chk("spurious_rdata", 64'(bus.REQ_RDATA), 64'd0);

        // Single read from requester 0.
        set_req(0, 4'h0, 32'h0000_1000, 32'h0);
        push_exp(2'b01, 4'h0, 32'h0000_1000, 32'h0);
        bus.REQ_ENA = 2'b01;
        service(5, 32'hDEAD_BEEF, 1'b0, 1'b0, waited);
        chk("issue_latency", 64'(waited), 64'd1);
        bus.REQ_ENA = 2'b00;
        step();

        // Both requesters held from reset: order 0,1,0,1.
        ARESETn = 1'b0;
        step();
        ARESETn = 1'b1;
        model_rdata = 32'h0;
        step();
        set_req(0, 4'h0, 32'h0000_2000, 32'h0);
        set_req(1, 4'h0, 32'h0000_3000, 32'h0);
        push_exp(2'b01, 4'h0, 32'h0000_2000, 32'h0);
        push_exp(2'b10, 4'h0, 32'h0000_3000, 32'h0);
        push_exp(2'b01, 4'h0, 32'h0000_2000, 32'h0);
        push_exp(2'b10, 4'h0, 32'h0000_3000, 32'h0);
        bus.REQ_ENA = 2'b11;
        service(2, 32'h1111_1111, 1'b0, 1'b0, waited);
        service(3, 32'h2222_2222, 1'b0, 1'b0, waited);
        service(1, 32'h3333_3333, 1'b0, 1'b0, waited);
        service(4, 32'h4444_4444, 1'b0, 1'b0, waited);
        bus.REQ_ENA = 2'b00;
        step();

        // Write from requester 1; its WDATA changes during WAIT.
        set_req(1, 4'hF, 32'h0000_4000, 32'hA5A5_A5A5);
        push_exp(2'b10, 4'hF, 32'h0000_4000, 32'hA5A5_A5A5);
        bus.REQ_ENA = 2'b10;
        service(3, 32'h0, 1'b0, 1'b1, waited);
        bus.REQ_ENA = 2'b00;
        step();

        // Requester 0 withdraws right after BUS_ENA.
        set_req(0, 4'h0, 32'h0000_5000, 32'h0);
        push_exp(2'b01, 4'h0, 32'h0000_5000, 32'h0);
        bus.REQ_ENA = 2'b01;
        service(2, 32'h5555_AAAA, 1'b1, 1'b0, waited);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("withdraw_no_reissue", 64'(bus.BUS_ENA), 64'd0);
        end

        // Reset during WAIT; last_grant is 0 here, so only a reset restores 0-first.
        set_req(0, 4'h0, 32'h0000_6000, 32'h0);
        bus.REQ_ENA = 2'b01;
        step();
        chk("rstwait_ena", 64'(bus.BUS_ENA), 64'd1);
        step();
        #2;
        ARESETn = 1'b0;
        bus.REQ_ENA = 2'b00;
        #1;
        chk("rstwait_grant", 64'(bus.GRANT), 64'd0);
        chk("rstwait_addr", 64'(bus.BUS_ADDR), 64'd0);
        chk("rstwait_rdata", 64'(bus.REQ_RDATA), 64'd0);
        chk("rstwait_ena_off", 64'(bus.BUS_ENA), 64'd0);
        model_rdata = 32'h0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rstwait_no_done", 64'(bus.REQ_DONE), 64'd0);
        end
        ARESETn = 1'b1;
        set_req(0, 4'h0, 32'h0000_7000, 32'h0);
        set_req(1, 4'h0, 32'h0000_8000, 32'h0);
        push_exp(2'b01, 4'h0, 32'h0000_7000, 32'h0);
        push_exp(2'b10, 4'h0, 32'h0000_8000, 32'h0);
        bus.REQ_ENA = 2'b11;
        service(2, 32'h7777_0000, 1'b0, 1'b0, waited);
        service(2, 32'h8888_0000, 1'b0, 1'b0, waited);
        bus.REQ_ENA = 2'b00;
        step();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
